// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude max tracker: field helpers and FSM states.
package sm_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int sign_bit(input int n);
    return n - 1;
  endfunction

  function automatic int mag_msb(input int n);
    return n - 2;
  endfunction

endpackage

// File: rtl/sm_max_tracker_if.sv
// Sample-in / result-out handshake bundle for sm_max_tracker.
interface sm_max_tracker_if #(
  parameter int N   = 8,
  parameter int LEN = 8
);
  localparam int IW = $clog2(LEN);

  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          o_ready;
  logic [N-1:0]  o_max;
  logic [IW-1:0] o_idx;
  logic          o_valid;
  logic          in_ack;

  modport master (
    output in_data, in_valid, in_ack,
    input  o_ready, o_max, o_idx, o_valid
  );

  modport slave (
    input  in_data, in_valid, in_ack,
    output o_ready, o_max, o_idx, o_valid
  );
endinterface

// File: rtl/comparator.sv
// Sign-magnitude a >= b comparator; +0 ranks above -0.
module comparator
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out
);
  localparam int S = sign_bit(N);
  localparam int M = mag_msb(N);

  logic [N-1:0] key_a;
  logic [N-1:0] key_b;

  // Map onto an unsigned key: positives above negatives, negative magnitudes inverted.
  always_comb begin
    key_a = in_a[S] ? {1'b0, ~in_a[M:0]} : {1'b1, in_a[M:0]};
    key_b = in_b[S] ? {1'b0, ~in_b[M:0]} : {1'b1, in_b[M:0]};
  end

  assign out = (key_a >= key_b);
endmodule

// File: rtl/sm_max_tracker.sv
// Per-frame running maximum (and its index) over LEN sign-magnitude samples.
module sm_max_tracker
  import sm_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sm_max_tracker_if.slave      bus
);
  localparam int IW = $clog2(LEN);
  localparam int CW = IW + 1;

  state_t        state_q, state_d;
  logic [N-1:0]  max_q,   max_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;

  logic          keep_max;
  logic          xfer;

  comparator #(.N(N)) u_cmp (
    .in_a (max_q),
    .in_b (bus.in_data),
    .out  (keep_max)
  );

  assign xfer = bus.in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    unique case (state_q)
      FIRST: begin
        if (xfer) begin
          max_d   = bus.in_data;
          idx_d   = '0;
          cnt_d   = CW'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          // Strictly-greater update keeps the first occurrence on ties.
          if (!keep_max) begin
            max_d = bus.in_data;
            idx_d = cnt_q[IW-1:0];
          end
          if (cnt_q == CW'(LEN - 1)) begin
            state_d = DONE;
            ready_d = 1'b0;
            valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.in_ack) begin
          state_d = FIRST;
          cnt_d   = '0;
          ready_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = FIRST;
        cnt_d   = '0;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FIRST;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_max   = max_q;
  assign bus.o_idx   = idx_q;
endmodule

// File: tb/tb_sm_max_tracker.sv
// Self-checking bench for sm_max_tracker (N=8, LEN=4) against a rank-based reference model.
module tb_sm_max_tracker;
  localparam int N   = 8;
  localparam int LEN = 4;
  localparam int IW  = $clog2(LEN);

  typedef logic [N-1:0] frame_t [LEN];

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  sm_max_tracker_if #(.N(N), .LEN(LEN)) bus_if ();

  sm_max_tracker #(.N(N), .LEN(LEN)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_if)
  );

  always #5 i_clk = ~i_clk;

  // Numeric value doubled, with +0 nudged above -0.
  function automatic int rank(input logic [N-1:0] v);
    int m;
    m = int'(v[N-2:0]);
    return v[N-1] ? -2 * m : 2 * m + 1;
  endfunction

  function automatic void ref_max(input frame_t f, output logic [N-1:0] mx, output logic [IW-1:0] ix);
    int best;
    best = rank(f[0]);
    mx = f[0];
    ix = '0;
    for (int i = 1; i < LEN; i++) begin
      if (rank(f[i]) > best) begin
        best = rank(f[i]);
        mx = f[i];
        ix = IW'(i);
      end
    end
  endfunction

  // Present one sample from a negedge; returns on the negedge after the accepting edge.
  task automatic drive_sample(input logic [N-1:0] d);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    @(negedge i_clk);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic ack_result();
    bus_if.in_ack = 1'b1;
    @(negedge i_clk);
    bus_if.in_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_if.o_valid); end
    checks++; if (bus_if.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus_if.o_ready); end
    checks++; if (bus_if.o_max !== 8'h00) begin failures++; $display("FAIL reset_max got=%h exp=00", bus_if.o_max); end
    checks++; if (bus_if.o_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus_if.o_idx); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_mixed();
    frame_t f;
    f = '{8'h05, 8'h83, 8'h10, 8'h0F};
    bus_if.in_ack = 1'b1;
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    $display("mixed: max=%h idx=%0d valid=%b", bus_if.o_max, bus_if.o_idx, bus_if.o_valid);
    checks++; if (bus_if.o_valid !== 1'b1) begin failures++; $display("FAIL mixed_valid got=%b exp=1", bus_if.o_valid); end
    checks++; if (bus_if.o_max !== 8'h10) begin failures++; $display("FAIL mixed_max got=%h exp=10", bus_if.o_max); end
    checks++; if (bus_if.o_idx !== 2'd2) begin failures++; $display("FAIL mixed_idx got=%0d exp=2", bus_if.o_idx); end
    checks++; if (bus_if.o_ready !== 1'b0) begin failures++; $display("FAIL mixed_ready_low got=%b exp=0", bus_if.o_ready); end
    @(negedge i_clk);
    checks++; if (bus_if.o_ready !== 1'b1) begin failures++; $display("FAIL mixed_ready_back got=%b exp=1", bus_if.o_ready); end
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("FAIL mixed_valid_fall got=%b exp=0", bus_if.o_valid); end
    bus_if.in_ack = 1'b0;
  endtask

  task automatic test_all_negative();
    frame_t f;
    f = '{8'h83, 8'h81, 8'h85, 8'h82};
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    $display("all_neg: max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    checks++; if (bus_if.o_max !== 8'h81) begin failures++; $display("FAIL neg_max got=%h exp=81", bus_if.o_max); end
    checks++; if (bus_if.o_idx !== 2'd1) begin failures++; $display("FAIL neg_idx got=%0d exp=1", bus_if.o_idx); end
    ack_result();
  endtask

  task automatic test_ties();
    frame_t f;
    f = '{8'h07, 8'h07, 8'h02, 8'h07};
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    $display("ties: max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    checks++; if (bus_if.o_max !== 8'h07) begin failures++; $display("FAIL tie_max got=%h exp=07", bus_if.o_max); end
    checks++; if (bus_if.o_idx !== 2'd0) begin failures++; $display("FAIL tie_idx got=%0d exp=0", bus_if.o_idx); end
    ack_result();
    f = '{8'h80, 8'h00, 8'h80, 8'h00};
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    $display("zeros: max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    checks++; if (bus_if.o_max !== 8'h00) begin failures++; $display("FAIL zero_max got=%h exp=00", bus_if.o_max); end
    checks++; if (bus_if.o_idx !== 2'd1) begin failures++; $display("FAIL zero_idx got=%0d exp=1", bus_if.o_idx); end
    ack_result();
  endtask

  task automatic test_backpressure();
    frame_t f;
    f = '{8'h11, 8'h22, 8'h33, 8'h22};
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    bus_if.in_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = k[0] ? 8'h70 : 8'h7F;
      @(negedge i_clk);
      checks++; if (bus_if.o_max !== 8'h33 || bus_if.o_idx !== 2'd2 || bus_if.o_valid !== 1'b1 || bus_if.o_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got max=%h idx=%0d v=%b r=%b exp max=33 idx=2 v=1 r=0",
                 k, bus_if.o_max, bus_if.o_idx, bus_if.o_valid, bus_if.o_ready);
      end
    end
    $display("backpressure: held max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    bus_if.in_data = 8'h01;
    bus_if.in_ack  = 1'b1;
    @(negedge i_clk);
    bus_if.in_ack = 1'b0;
    checks++; if (bus_if.o_ready !== 1'b1 || bus_if.o_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", bus_if.o_ready, bus_if.o_valid);
    end
    f = '{8'h01, 8'h81, 8'h82, 8'h83};
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    $display("bp_next: max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    checks++; if (bus_if.o_valid !== 1'b1 || bus_if.o_max !== 8'h01 || bus_if.o_idx !== 2'd0) begin
      failures++; $display("FAIL bp_next got v=%b max=%h idx=%0d exp v=1 max=01 idx=0", bus_if.o_valid, bus_if.o_max, bus_if.o_idx);
    end
    ack_result();
  endtask

  task automatic test_gaps();
    frame_t f;
    logic [N-1:0] m;
    logic [IW-1:0] x;
    logic v, r;
    f = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < LEN; i++) begin
      drive_sample(f[i]);
      m = bus_if.o_max; x = bus_if.o_idx; v = bus_if.o_valid; r = bus_if.o_ready;
      bus_if.in_data = 8'h7F;
      @(negedge i_clk);
      checks++; if (bus_if.o_max !== m || bus_if.o_idx !== x || bus_if.o_valid !== v || bus_if.o_ready !== r) begin
        failures++;
        $display("FAIL gap_hold i=%0d got max=%h idx=%0d v=%b r=%b exp max=%h idx=%0d v=%b r=%b",
                 i, bus_if.o_max, bus_if.o_idx, bus_if.o_valid, bus_if.o_ready, m, x, v, r);
      end
    end
    $display("gaps: max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    checks++; if (bus_if.o_valid !== 1'b1 || bus_if.o_max !== 8'h04 || bus_if.o_idx !== 2'd3) begin
      failures++; $display("FAIL gap_result got v=%b max=%h idx=%0d exp v=1 max=04 idx=3", bus_if.o_valid, bus_if.o_max, bus_if.o_idx);
    end
    ack_result();
  endtask

  task automatic test_reset_mid();
    frame_t f;
    drive_sample(8'h33);
    drive_sample(8'h44);
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (bus_if.o_valid !== 1'b0 || bus_if.o_ready !== 1'b1 || bus_if.o_max !== 8'h00 || bus_if.o_idx !== 2'd0) begin
      failures++; $display("FAIL rst_async got v=%b r=%b max=%h idx=%0d exp v=0 r=1 max=00 idx=0",
                           bus_if.o_valid, bus_if.o_ready, bus_if.o_max, bus_if.o_idx);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    f = '{8'h09, 8'h01, 8'h01, 8'h01};
    for (int i = 0; i < LEN; i++) drive_sample(f[i]);
    $display("after_reset: max=%h idx=%0d", bus_if.o_max, bus_if.o_idx);
    checks++; if (bus_if.o_valid !== 1'b1 || bus_if.o_max !== 8'h09 || bus_if.o_idx !== 2'd0) begin
      failures++; $display("FAIL rst_next got v=%b max=%h idx=%0d exp v=1 max=09 idx=0", bus_if.o_valid, bus_if.o_max, bus_if.o_idx);
    end
    ack_result();
  endtask

  task automatic test_random();
    frame_t f;
    logic [N-1:0] mx;
    logic [IW-1:0] ix;
    int sel;
    for (int fr = 0; fr < 40; fr++) begin
      for (int i = 0; i < LEN; i++) begin
        sel = int'($urandom_range(0, 5));
        if (sel == 0)      f[i] = 8'h00;
        else if (sel == 1) f[i] = 8'h80;
        else               f[i] = N'($urandom);
      end
      ref_max(f, mx, ix);
      for (int i = 0; i < LEN; i++) begin
        drive_sample(f[i]);
        if (i < LEN - 1) repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end
      $display("rand frame %0d: %h %h %h %h -> max=%h idx=%0d (exp %h/%0d)",
               fr, f[0], f[1], f[2], f[3], bus_if.o_max, bus_if.o_idx, mx, ix);
      checks++; if (bus_if.o_valid !== 1'b1 || bus_if.o_max !== mx || bus_if.o_idx !== ix) begin
        failures++; $display("FAIL rand_frame %0d got v=%b max=%h idx=%0d exp v=1 max=%h idx=%0d",
                             fr, bus_if.o_valid, bus_if.o_max, bus_if.o_idx, mx, ix);
      end
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      ack_result();
    end
  endtask

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_ack   = 1'b0;
    test_reset();
    test_mixed();
    test_all_negative();
    test_ties();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_max_tracker.md
# sm_max_tracker

- Streaming reduction stage that consumes LEN sign-magnitude samples per frame and reports the largest value and its index.
- Sits directly downstream of the team's sign-magnitude `comparator`: that comparator is instantiated inside this block and its a≥b result drives the running-max update.
- Valid/ready handshake on both the input and result sides.

## Interface
Parameters:
- N, 8, sample width; bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude.
- LEN, 8, samples per frame; LEN ≥ 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  N  sign-magnitude sample.
- in_valid  in  1  in_data valid.
- o_ready  out  1  block accepts a sample this cycle.
- o_max  out  N  frame maximum, sign-magnitude.
- o_idx  out  $clog2(LEN)  position of o_max in the frame; first sample is 0.
- o_valid  out  1  o_max/o_idx valid.
- in_ack  in  1  downstream accepts the result.

## Operation
- A transfer occurs when in_valid && o_ready at a rising edge.
- FSM states:
  - FIRST: o_ready=1. On transfer, load max_r ← in_data, idx_r ← 0, cnt ← 1, and go to ACCUM.
  - ACCUM: o_ready=1. On transfer, cnt increments.
    - Comparator inputs: in_a = max_r, in_b = in_data.
    - If comparator out = 0 (new sample strictly greater), load max_r ← in_data and idx_r ← cnt.
    - When the accepted sample is number LEN (cnt = LEN-1 before increment), go to DONE.
  - DONE: o_ready=0, o_valid=1. o_max = max_r, o_idx = idx_r.
    - When in_ack=1 at an edge, go to FIRST and clear cnt.
    - in_valid is ignored while in DONE.
- Ordering follows the comparator exactly:
  - Any positive value is greater than any negative value.
  - Positives are ordered by magnitude ascending; negatives by magnitude descending.
  - +0 (0x00) is greater than -0 (0x80 for N=8).
- Ties: the first occurrence is kept, because updates happen only on strictly greater.
- Arithmetic:
  - cnt is $clog2(LEN)+1 bits wide and never wraps within a frame.
  - No arithmetic is performed on samples; values are passed through unchanged.
- Idle cycles (in_valid=0) in FIRST or ACCUM hold all state.
- Reset mid-frame: the partial frame is discarded. After release, the next accepted sample is index 0 of a new frame.

## Timing
- Reset values: state FIRST, o_valid 0, o_ready 1, o_max 0, o_idx 0, cnt 0.
- o_max and o_idx are registered. o_ready and o_valid are decoded from the state register only, so there is no combinational path from in_valid or in_ack.
- Latency: o_valid rises on the edge that accepts sample LEN, so results are visible in the following cycle.
- o_valid falls on the edge where in_ack=1 is sampled. o_ready is 1 from the next cycle.
- Throughput: at most one frame per LEN+1 cycles (one DONE cycle minimum).
- Backpressure: while in DONE with in_ack=0, o_max, o_idx and o_valid are held stable for any number of cycles.
- in_ack outside DONE has no effect.

## Structure
- Shared package sm_pkg holds:
  - sign/magnitude field helpers: sign bit index N-1, magnitude slice N-2:0;
  - the state enum typedef {FIRST, ACCUM, DONE}.
- One sub-module: the existing `comparator` (parameter N passed through), instantiated once.
- Top-level content is the FSM, counter and result registers. The expected size is about 150 lines.

## Test plan
All scenarios use N=8, LEN=4.
1. Mixed frame 0x05, 0x83, 0x10, 0x0F, back-to-back with in_ack=1 → o_valid one cycle after the 4th transfer; o_max=0x10, o_idx=2; o_ready low for exactly one cycle.
2. All-negative frame 0x83, 0x81, 0x85, 0x82 → o_max=0x81 (-1), o_idx=1.
3. Ties and signed zeros:
   - 0x07, 0x07, 0x02, 0x07 → o_idx=0;
   - 0x80, 0x00, 0x80, 0x00 → o_max=0x00, o_idx=1.
4. Backpressure: in_ack=0 for 5 cycles after o_valid, with in_valid=1 and in_data toggling → o_max and o_idx stable, o_ready=0, no sample consumed; after in_ack=1, the next frame starts with the pending in_data as index 0.
5. Input gaps: in_valid asserted on alternate cycles for frame 0x01, 0x02, 0x03, 0x04 → o_max=0x04, o_idx=3; nothing changes on idle cycles.
6. Reset mid-frame: assert i_rst_n=0 asynchronously after 2 samples, between edges → all outputs take reset values immediately; the next frame 0x09, 0x01, 0x01, 0x01 gives o_max=0x09, o_idx=0.
